// File: rtl/sudoku_solve_ctrl_if.sv
// ============================================================================
//  Module      : sudoku_solve_ctrl_if
//  Description : Handshake and mask bus between the sudoku solve controller,
//                its requester and the external stage-2 elimination datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sudoku_solve_ctrl_if;
    logic         start;
    logic [728:0] mask_in;
    logic [728:0] stg_mask_out;
    logic [728:0] stg_mask_in;
    logic         busy;
    logic         done;
    logic [2:0]   status;
    logic [4:0]   iter_cnt;
    logic [728:0] mask_out;

    // Controller side
    modport slave (
        input  start, mask_in, stg_mask_in,
        output stg_mask_out, busy, done, status, iter_cnt, mask_out
    );

    // Requester / datapath side
    modport master (
        output start, mask_in, stg_mask_in,
        input  stg_mask_out, busy, done, status, iter_cnt, mask_out
    );
endinterface

`default_nettype wire

// File: rtl/sudoku_solve_ctrl.sv
// ============================================================================
//  Module      : sudoku_solve_ctrl
//  Description : Iterates an external elimination datapath over a 9x9x9
//                candidate mask until the grid is solved, stuck, in conflict
//                or the pass budget MAX_ITER is exhausted.
//                Optional macro SUDOKU_SOLVE_CTRL_STG_PIPE_EN registers the
//                datapath result and adds a WAIT state (2 cycles per pass).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sudoku_solve_ctrl #(
    parameter int MAX_ITER = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sudoku_solve_ctrl_if.slave bus
);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_RUN  = 2'd1;
    localparam logic [1:0] C_ST_FIN  = 2'd2;
`ifdef SUDOKU_SOLVE_CTRL_STG_PIPE_EN
    localparam logic [1:0] C_ST_WAIT = 2'd3;
`endif

    localparam logic [2:0] C_STAT_NONE     = 3'd0;
    localparam logic [2:0] C_STAT_SOLVED   = 3'd1;
    localparam logic [2:0] C_STAT_STUCK    = 3'd2;
    localparam logic [2:0] C_STAT_CONFLICT = 3'd3;
    localparam logic [2:0] C_STAT_TIMEOUT  = 3'd4;

    localparam logic [4:0] C_MAX_ITER = 5'(MAX_ITER);

    logic [1:0]   state_q, state_d;
    logic [728:0] mask_q, mask_d;
    logic [4:0]   iter_cnt_q, iter_cnt_d;
    logic [2:0]   status_q, status_d;

    // Mask proposed by the datapath for the current mask_q
    logic [728:0] w_next;

`ifdef SUDOKU_SOLVE_CTRL_STG_PIPE_EN
    logic [728:0] stg_q, stg_d;
    assign stg_d  = bus.stg_mask_in;
    assign w_next = stg_q;
`else
    assign w_next = bus.stg_mask_in;
`endif

    // Per-cell classification of the current mask (cell index x*9+y)
    logic [80:0] w_conflict;
    logic [80:0] w_single;

    generate
        for (genvar c = 0; c < 81; c++) begin : g_cell
            logic [8:0] w_bits;
            logic [8:0] w_free;
            assign w_bits        = mask_q[c*9 +: 9];
            assign w_free        = ~w_bits;
            assign w_conflict[c] = &w_bits;
            // Exactly one candidate left: the free-bit vector is one-hot
            assign w_single[c]   = (w_free != 9'd0) &&
                                   ((w_free & (w_free - 9'd1)) == 9'd0);
        end
    endgenerate

    logic w_any_conflict;
    logic w_all_single;
    logic w_fixpoint;
    logic w_timeout;

    assign w_any_conflict = |w_conflict;
    assign w_all_single   = &w_single;
    assign w_fixpoint     = (w_next == mask_q);
    assign w_timeout      = (iter_cnt_q == C_MAX_ITER);

    // State and datapath registers, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= C_ST_IDLE;
            mask_q     <= '0;
            iter_cnt_q <= '0;
            status_q   <= C_STAT_NONE;
`ifdef SUDOKU_SOLVE_CTRL_STG_PIPE_EN
            stg_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            iter_cnt_q <= iter_cnt_d;
            status_q   <= status_d;
`ifdef SUDOKU_SOLVE_CTRL_STG_PIPE_EN
            stg_q      <= stg_d;
`endif
        end
    end

    // Next-state logic: accept a run, commit passes, classify termination
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        iter_cnt_d = iter_cnt_q;
        status_d   = status_q;
        case (state_q)
            C_ST_IDLE: begin
                if (bus.start) begin
                    mask_d     = bus.mask_in;
                    iter_cnt_d = '0;
                    status_d   = C_STAT_NONE;
`ifdef SUDOKU_SOLVE_CTRL_STG_PIPE_EN
                    state_d    = C_ST_WAIT;
`else
                    state_d    = C_ST_RUN;
`endif
                end
            end
`ifdef SUDOKU_SOLVE_CTRL_STG_PIPE_EN
            C_ST_WAIT: begin
                state_d = C_ST_RUN;
            end
`endif
            C_ST_RUN: begin
                if (w_any_conflict) begin
                    status_d = C_STAT_CONFLICT;
                    state_d  = C_ST_FIN;
                end else if (w_all_single) begin
                    status_d = C_STAT_SOLVED;
                    state_d  = C_ST_FIN;
                end else if (w_fixpoint) begin
                    status_d = C_STAT_STUCK;
                    state_d  = C_ST_FIN;
                end else if (w_timeout) begin
                    status_d = C_STAT_TIMEOUT;
                    state_d  = C_ST_FIN;
                end else begin
                    mask_d     = w_next;
                    iter_cnt_d = iter_cnt_q + 5'd1;
`ifdef SUDOKU_SOLVE_CTRL_STG_PIPE_EN
                    state_d    = C_ST_WAIT;
`endif
                end
            end
            C_ST_FIN: begin
                state_d = C_ST_IDLE;
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        bus.stg_mask_out = mask_q;
        bus.mask_out     = mask_q;
        bus.busy         = (state_q != C_ST_IDLE);
        bus.done         = (state_q == C_ST_FIN);
        bus.status       = status_q;
        bus.iter_cnt     = iter_cnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_sudoku_solve_ctrl.sv
// ============================================================================
//  Module      : tb_sudoku_solve_ctrl
//  Description : Directed, table-driven bench for sudoku_solve_ctrl with a
//                behavioural elimination datapath model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sudoku_solve_ctrl;

    localparam int MAX_ITER = 4;

`ifdef SUDOKU_SOLVE_CTRL_STG_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    sudoku_solve_ctrl_if bus_if();

    sudoku_solve_ctrl #(.MAX_ITER(MAX_ITER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    // Datapath model: 0 identity, 1 set lowest clear bit, 2 OR with target
    logic [1:0]   dp_mode   = 2'd0;
    logic [728:0] dp_target = '0;

    always_comb begin
        bus_if.stg_mask_in = bus_if.stg_mask_out;
        case (dp_mode)
            2'd1:    bus_if.stg_mask_in = bus_if.stg_mask_out | (bus_if.stg_mask_out + 729'd1);
            2'd2:    bus_if.stg_mask_in = bus_if.stg_mask_out | dp_target;
            default: bus_if.stg_mask_in = bus_if.stg_mask_out;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string        name;
        logic [728:0] mask;
        logic [1:0]   mode;
        logic [728:0] target;
        logic [2:0]   st;
        logic [4:0]   it;
        logic [728:0] em;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [728:0] solved_grid();
        logic [728:0] g;
        int v;
        g = '0;
        for (int x = 0; x < 9; x++) begin
            for (int y = 0; y < 9; y++) begin
                v = (x*3 + x/3 + y) % 9;
                g[(x*81 + y*9) +: 9] = 9'h1FF & ~(9'd1 << v);
            end
        end
        return g;
    endfunction

    function automatic int exp_lat(input int it);
        return (PIPE != 0) ? (2*it + 3) : (it + 2);
    endfunction

    task automatic check(input string name, input logic [728:0] act, input logic [728:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for done (start already removed, now in cycle 1) and check the result
    task automatic wait_done(input string name, input logic [2:0] st,
                             input logic [4:0] it, input logic [728:0] em);
        int lat;
        bit seen;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 100) begin
            if (bus_if.done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: got no done expected done within 100 cycles", name);
        end else begin
            check($sformatf("%s.latency", name), 729'(lat), 729'(exp_lat(int'(it))));
            check($sformatf("%s.status", name), 729'(bus_if.status), 729'(st));
            check($sformatf("%s.iter_cnt", name), 729'(bus_if.iter_cnt), 729'(it));
            check($sformatf("%s.mask_out", name), bus_if.mask_out, em);
            check($sformatf("%s.busy_at_done", name), 729'(bus_if.busy), 729'd1);
            @(negedge clk);
            check($sformatf("%s.done_pulse", name), 729'(bus_if.done), 729'd0);
            check($sformatf("%s.status_hold", name), 729'(bus_if.status), 729'(st));
            check($sformatf("%s.iter_hold", name), 729'(bus_if.iter_cnt), 729'(it));
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        dp_mode        = v.mode;
        dp_target      = v.target;
        bus_if.mask_in = v.mask;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start   = 1'b0;
        wait_done(v.name, v.st, v.it, v.em);
    endtask

    initial begin
        logic [728:0] solved;
        logic [728:0] c00;
        int p;
        int dones;
        int ph;

        solved = solved_grid();
        c00    = '0;
        c00[8:0] = 9'h1FF;

        vecs[0] = '{"solved",        solved,         2'd0, '0,     3'd1, 5'd0, solved};
        vecs[1] = '{"conflict00",    c00,            2'd0, '0,     3'd3, 5'd0, c00};
        vecs[2] = '{"conflict_solv", solved | c00,   2'd0, '0,     3'd3, 5'd0, solved | c00};
        vecs[3] = '{"stuck_zero",    '0,             2'd0, '0,     3'd2, 5'd0, '0};
        vecs[4] = '{"timeout",       '0,             2'd1, '0,     3'd4, 5'd4, 729'hF};
        vecs[5] = '{"conflict_pass", 729'hFF,        2'd1, '0,     3'd3, 5'd1, 729'h1FF};
        vecs[6] = '{"solve_pass",    '0,             2'd2, solved, 3'd1, 5'd1, solved};
        vecs[7] = '{"stuck_pass",    '0,             2'd2, 729'h3, 3'd2, 5'd1, 729'h3};

        bus_if.start   = 1'b0;
        bus_if.mask_in = '0;

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #2;
        check("reset.busy",     729'(bus_if.busy),     729'd0);
        check("reset.done",     729'(bus_if.done),     729'd0);
        check("reset.status",   729'(bus_if.status),   729'd0);
        check("reset.iter_cnt", 729'(bus_if.iter_cnt), 729'd0);
        check("reset.mask_out", bus_if.mask_out,       '0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the middle of a never-ending run
        @(negedge clk);
        dp_mode        = 2'd1;
        bus_if.mask_in = '0;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst.iter_before", 729'(bus_if.iter_cnt), 729'((PIPE != 0) ? 1 : 2));
        #1 rst_n = 1'b0;
        #1;
        check("midrst.busy",     729'(bus_if.busy),     729'd0);
        check("midrst.done",     729'(bus_if.done),     729'd0);
        check("midrst.status",   729'(bus_if.status),   729'd0);
        check("midrst.iter_cnt", 729'(bus_if.iter_cnt), 729'd0);
        check("midrst.mask_out", bus_if.mask_out,       '0);
        // Release and request on the same cycle: first edge must accept
        @(negedge clk);
        rst_n          = 1'b1;
        dp_mode        = 2'd0;
        bus_if.mask_in = solved;
        bus_if.start   = 1'b1;
        @(negedge clk);
        bus_if.start   = 1'b0;
        wait_done("after_rst", 3'd1, 5'd0, solved);

        // start held high: back-to-back runs with one idle cycle between
        @(negedge clk);
        dp_mode        = 2'd0;
        bus_if.mask_in = solved;
        bus_if.start   = 1'b1;
        p     = (PIPE != 0) ? 4 : 3;
        dones = 0;
        for (int k = 1; k <= 3*p; k++) begin
            @(negedge clk);
            ph = (k - 1) % p;
            if (bus_if.done) dones++;
            check($sformatf("held.busy[%0d]", k), 729'(bus_if.busy), 729'(ph != p - 1));
            check($sformatf("held.done[%0d]", k), 729'(bus_if.done), 729'(ph == p - 2));
        end
        check("held.done_count", 729'(dones), 729'd3);
        bus_if.start = 1'b0;
        repeat (p + 1) @(negedge clk);
        check("held.final_idle", 729'(bus_if.busy), 729'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sudoku_solve_ctrl.md
SUDOKU_SOLVE_CTRL -- requirements
Module: sudoku_solve_ctrl

Interface
REQ-001 SHALL have parameter MAX_ITER, default 16, meaning the maximum number of elimination passes per run (legal range 1..31).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-005 SHALL have port mask_in  input  729  initial elimination mask; bit set means the candidate is eliminated; index x*81+y*9+v.
REQ-006 SHALL have port stg_mask_out  output  729  mask driven to the external stage-2 elimination datapath.
REQ-007 SHALL have port stg_mask_in  input  729  datapath result, combinational function of stg_mask_out.
REQ-008 SHALL have port busy  output  1  high from the cycle after start acceptance until the done cycle inclusive.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking the end of a run.
REQ-010 SHALL have port status  output  3  run outcome: 0 none, 1 solved, 2 stuck, 3 conflict, 4 timeout.
REQ-011 SHALL have port iter_cnt  output  5  number of passes committed in the current or last run.
REQ-012 SHALL have port mask_out  output  729  final mask, equal to the internal mask register.

Function
REQ-013 SHALL implement states IDLE, RUN, FIN; stg_mask_out SHALL equal the internal mask register mask_q at all times.
REQ-014 IDLE with start=1 SHALL load mask_q<=mask_in, clear iter_cnt and status, and enter RUN next cycle; start=0 SHALL hold.
REQ-015 Cell (x,y) SHALL be conflict when all 9 bits are set, and single when exactly 8 bits are set; the evaluation uses mask_q, combinationally.
REQ-016 In RUN, priority per cycle SHALL be: any conflict cell -> status 3; else all 81 cells single -> status 1; else stg_mask_in==mask_q -> status 2; else iter_cnt==MAX_ITER -> status 4; in all four cases go to FIN.
REQ-017 In RUN when no REQ-016 condition holds, mask_q SHALL load stg_mask_in and iter_cnt SHALL increment, giving one pass per clock.
REQ-018 FIN SHALL last exactly one cycle with done=1 and then return to IDLE; status, iter_cnt and mask_out SHALL hold until the next accepted start.
REQ-019 start asserted in RUN or FIN SHALL be ignored; it is not queued.
REQ-020 iter_cnt SHALL never exceed MAX_ITER and SHALL not wrap.
REQ-021 Latency from start to done SHALL be iter_cnt+2 cycles (one RUN cycle per committed pass plus the terminating RUN cycle plus FIN).

Reset
REQ-022 rst_n low SHALL immediately force state IDLE, mask_q=0, iter_cnt=0, status=0, busy=0, done=0, including mid-run; no partial result is retained.
REQ-023 After rst_n deassertion the block SHALL accept start on the first rising edge.

Configuration
REQ-024 Macro SUDOKU_SOLVE_CTRL_STG_PIPE_EN defined: stg_mask_in SHALL be registered into an internal stage register and an extra state WAIT inserted before each RUN evaluation, giving 2 cycles per pass and latency 2*iter_cnt+3.
REQ-025 Macro SUDOKU_SOLVE_CTRL_STG_PIPE_EN undefined: no stage register and no WAIT state; the timing of REQ-021 applies.
REQ-026 Status priorities, reset values and iter_cnt semantics SHALL be identical in both builds.

Verification
REQ-027 Stimulus: mask_in already fully single (a valid solved grid). Required: done 2 cycles after start, status=1, iter_cnt=0, mask_out=mask_in.
REQ-028 Stimulus: mask_in with cell (0,0) all 9 bits set. Required: status=3, iter_cnt=0, regardless of the other cells.
REQ-029 Stimulus: all-zero mask_in, with the datapath returning its input unchanged. Required: status=2, iter_cnt=0, done at cycle 2.
REQ-030 Stimulus: the datapath model sets one new bit per pass and never reaches a fixpoint; MAX_ITER=4. Required: status=4, iter_cnt=4, done at cycle 6.
REQ-031 Stimulus: rst_n pulsed low at cycle 3 of a run, then start reissued. Required: outputs reset asynchronously and the second run completes normally.
REQ-032 Stimulus: start held high throughout a run. Required: exactly one run per IDLE entry, busy low for exactly one cycle between runs, and each done is a single-cycle pulse.
